// File: rtl/imm_gen_stage.sv
// Registered immediate generator with a 2-entry skid buffer (main + skid register).
// Optional Z-format (CSR zimm) support is enabled by defining IMMGEN_ZIMM_EN.
module imm_gen_stage #(
    parameter int XLEN        = 64,
    parameter int AUTO_DECODE = 1,
    parameter int TAG_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] FMT_I    = 3'b000;
    localparam logic [2:0] FMT_S    = 3'b001;
    localparam logic [2:0] FMT_B    = 3'b010;
    localparam logic [2:0] FMT_J    = 3'b011;
    localparam logic [2:0] FMT_U    = 3'b100;
    localparam logic [2:0] FMT_Z    = 3'b101;
    localparam logic [2:0] FMT_NONE = 3'b111;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    function automatic void decode_fmt(
        input  logic [31:0] instr,
        input  logic [2:0]  src,
        output logic [2:0]  fmt,
        output logic        ill
    );
        fmt = FMT_NONE;
        ill = 1'b0;
        if (AUTO_DECODE != 0) begin
            case (instr[6:0])
                7'b0000011, 7'b0010011, 7'b1100111: fmt = FMT_I;
                7'b0011011: begin
                    if (XLEN == 64) fmt = FMT_I;
                    else            ill = 1'b1;
                end
                7'b1110011: begin
`ifdef IMMGEN_ZIMM_EN
                    fmt = instr[14] ? FMT_Z : FMT_I;
`else
                    fmt = FMT_I;
`endif
                end
                7'b0100011:             fmt = FMT_S;
                7'b1100011:             fmt = FMT_B;
                7'b1101111:             fmt = FMT_J;
                7'b0110111, 7'b0010111: fmt = FMT_U;
                7'b0110011:             fmt = FMT_NONE;
                7'b0111011: begin
                    if (XLEN != 64) ill = 1'b1;
                end
                default:                ill = 1'b1;
            endcase
        end else begin
            case (src)
                FMT_I, FMT_S, FMT_B, FMT_J, FMT_U: fmt = src;
`ifdef IMMGEN_ZIMM_EN
                FMT_Z:   fmt = FMT_Z;
`endif
                default: ill = 1'b1;
            endcase
        end
    endfunction

    // Every format is assembled as a signed 32-bit value, then sign-extended to XLEN.
    function automatic logic signed [XLEN-1:0] build_imm(
        input logic [31:0] instr,
        input logic [2:0]  fmt
    );
        logic signed [31:0] raw;
        case (fmt)
            FMT_I:   raw = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_U:   raw = {instr[31:12], 12'b0};
            FMT_Z:   raw = {27'b0, instr[19:15]};
            default: raw = '0;
        endcase
        return XLEN'(raw);
    endfunction

    // Stage 0: combinational decode of the incoming instruction
    logic signed [XLEN-1:0] dec_imm_p0;
    logic [2:0]             dec_fmt_p0;
    logic                   dec_ill_p0;

    always_comb begin
        dec_fmt_p0 = FMT_NONE;
        dec_ill_p0 = 1'b0;
        decode_fmt(in_instr, in_imm_src, dec_fmt_p0, dec_ill_p0);
        dec_imm_p0 = build_imm(in_instr, dec_fmt_p0);
    end

    // Stage 1: main (output) register and skid register
    state_t                 state;
    logic signed [XLEN-1:0] imm_p1;
    logic [2:0]             fmt_p1;
    logic                   ill_p1;
    logic [TAG_W-1:0]       tag_p1;
    logic signed [XLEN-1:0] skid_imm_p1;
    logic [2:0]             skid_fmt_p1;
    logic                   skid_ill_p1;
    logic [TAG_W-1:0]       skid_tag_p1;

    logic in_fire;
    logic out_fire;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign out_imm     = imm_p1;
    assign out_fmt     = fmt_p1;
    assign out_illegal = ill_p1;
    assign out_tag     = tag_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            imm_p1 <= '0;
            fmt_p1 <= FMT_NONE;
            ill_p1 <= 1'b0;
            tag_p1 <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        imm_p1 <= dec_imm_p0;
                        fmt_p1 <= dec_fmt_p0;
                        ill_p1 <= dec_ill_p0;
                        tag_p1 <= in_tag;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        imm_p1 <= dec_imm_p0;
                        fmt_p1 <= dec_fmt_p0;
                        ill_p1 <= dec_ill_p0;
                        tag_p1 <= in_tag;
                    end else if (in_fire) begin
                        state <= TWO;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        imm_p1 <= skid_imm_p1;
                        fmt_p1 <= skid_fmt_p1;
                        ill_p1 <= skid_ill_p1;
                        tag_p1 <= skid_tag_p1;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Skid contents are only consumed when state says they are valid, so no reset is needed.
    always_ff @(posedge clk) begin
        if (state == ONE && in_fire && !out_fire) begin
            skid_imm_p1 <= dec_imm_p0;
            skid_fmt_p1 <= dec_fmt_p0;
            skid_ill_p1 <= dec_ill_p0;
            skid_tag_p1 <= in_tag;
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: instance a is XLEN=64 auto-decode, instance b is XLEN=32 manual select.
module tb_imm_gen_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
    logic [31:0] a_in_instr;
    logic [2:0]  a_in_imm_src, a_out_fmt;
    logic [7:0]  a_in_tag, a_out_tag;
    logic [63:0] a_out_imm;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
    logic [31:0] b_in_instr;
    logic [2:0]  b_in_imm_src, b_out_fmt;
    logic [7:0]  b_in_tag, b_out_tag;
    logic [31:0] b_out_imm;

    imm_gen_stage #(.XLEN(64), .AUTO_DECODE(1), .TAG_W(8)) u_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr),
        .in_imm_src(a_in_imm_src), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
        .out_fmt(a_out_fmt), .out_illegal(a_out_illegal), .out_tag(a_out_tag)
    );

    imm_gen_stage #(.XLEN(32), .AUTO_DECODE(0), .TAG_W(8)) u_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr),
        .in_imm_src(b_in_imm_src), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
        .out_fmt(b_out_fmt), .out_illegal(b_out_illegal), .out_tag(b_out_tag)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [7:0]  tag;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int total = 0;
    int bad   = 0;

    logic        held [2];
    logic [75:0] last [2];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic observe(input int d, input logic v, input logic rdy, input logic [63:0] imm,
                           input logic [2:0] fmt, input logic ill, input logic [7:0] tag);
        logic [75:0] cur;
        exp_t e;
        cur = {imm, fmt, ill, tag};
        if (reset || !v) begin
            held[d] = 1'b0;
            return;
        end
        if (held[d]) check($sformatf("hold%0d", d), 80'(cur), 80'(last[d]));
        if (rdy) begin
            if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
                total++;
                bad++;
                $display("FAIL unexpected_out%0d: got tag %h, expected no output", d, tag);
            end else begin
                e = (d == 0) ? qa.pop_front() : qb.pop_front();
                check($sformatf("imm%0d_tag%h", d, e.tag), 80'(imm), 80'(e.imm));
                check($sformatf("fmt%0d_tag%h", d, e.tag), 80'(fmt), 80'(e.fmt));
                check($sformatf("ill%0d_tag%h", d, e.tag), 80'(ill), 80'(e.ill));
                check($sformatf("tag%0d", d), 80'(tag), 80'(e.tag));
            end
        end
        held[d] = !rdy;
        last[d] = cur;
    endtask

    always @(negedge clk) begin
        observe(0, a_out_valid, a_out_ready, a_out_imm, a_out_fmt, a_out_illegal, a_out_tag);
        observe(1, b_out_valid, b_out_ready, {32'b0, b_out_imm}, b_out_fmt, b_out_illegal, b_out_tag);
    end

    // Called at posedge+#1; returns at posedge+#1 after the transfer edge.
    task automatic send(input int d, input logic [31:0] instr, input logic [2:0] src, input logic [7:0] tag,
                        input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
        exp_t e;
        int   n;
        logic rdy;
        e.imm = imm; e.fmt = fmt; e.ill = ill; e.tag = tag;
        if (d == 0) begin
            a_in_valid = 1'b1; a_in_instr = instr; a_in_imm_src = src; a_in_tag = tag;
        end else begin
            b_in_valid = 1'b1; b_in_instr = instr; b_in_imm_src = src; b_in_tag = tag;
        end
        n = 0;
        do begin
            @(negedge clk);
            rdy = (d == 0) ? a_in_ready : b_in_ready;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL send_timeout%0d: got in_ready 0 for %0d cycles, expected 1", d, n);
        end else if (d == 0) begin
            qa.push_back(e);
        end else begin
            qb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (d == 0) a_in_valid = 1'b0;
        else        b_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d/%0d pending, expected 0/0", qa.size(), qb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_in_valid = 0; a_in_instr = '0; a_in_imm_src = '0; a_in_tag = '0; a_out_ready = 1;
        b_in_valid = 0; b_in_instr = '0; b_in_imm_src = '0; b_in_tag = '0; b_out_ready = 1;
        held[0] = 0; held[1] = 0; last[0] = '0; last[1] = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_out_valid", 80'(a_out_valid), 80'(0));
        check("rst_out_imm", 80'(a_out_imm), 80'(0));
        check("rst_out_fmt", 80'(a_out_fmt), 80'(3'b111));
        check("rst_out_illegal", 80'(a_out_illegal), 80'(0));
        check("rst_out_tag", 80'(a_out_tag), 80'(0));
        check("rst_in_ready", 80'(a_in_ready), 80'(1));
        @(posedge clk);
        #1;

        // XLEN=64, auto decode
        send(0, 32'hFFF00093, 3'b000, 8'h10, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 0);
        send(0, 32'h80000037, 3'b110, 8'h11, 64'hFFFF_FFFF_8000_0000, 3'b100, 0);
        send(0, 32'hFE000EE3, 3'b000, 8'h12, 64'hFFFF_FFFF_FFFF_FFFC, 3'b010, 0);
        send(0, 32'h800000EF, 3'b000, 8'h13, 64'hFFFF_FFFF_FFF0_0000, 3'b011, 0);
`ifdef IMMGEN_ZIMM_EN
        send(0, 32'h3002D073, 3'b000, 8'h14, 64'h5, 3'b101, 0);
`else
        send(0, 32'h3002D073, 3'b000, 8'h14, 64'h300, 3'b000, 0);
`endif
        send(0, 32'hFE112E23, 3'b000, 8'h15, 64'hFFFF_FFFF_FFFF_FFFC, 3'b001, 0);
        send(0, 32'h002081B3, 3'b000, 8'h16, 64'h0, 3'b111, 0);
        send(0, 32'h0050809B, 3'b000, 8'h17, 64'h5, 3'b000, 0);
        send(0, 32'h0000007F, 3'b000, 8'h18, 64'h0, 3'b111, 1);

        // XLEN=32, manual format select
        send(1, 32'h80000037, 3'b100, 8'h20, 64'h8000_0000, 3'b100, 0);
        send(1, 32'hFFF00093, 3'b000, 8'h21, 64'hFFFF_FFFF, 3'b000, 0);
        send(1, 32'hFE112E23, 3'b001, 8'h22, 64'hFFFF_FFFC, 3'b001, 0);
        send(1, 32'h800000EF, 3'b011, 8'h23, 64'hFFF0_0000, 3'b011, 0);
        send(1, 32'hFFF00093, 3'b110, 8'h24, 64'h0, 3'b111, 1);
        send(1, 32'hFFF00093, 3'b111, 8'h25, 64'h0, 3'b111, 1);
`ifdef IMMGEN_ZIMM_EN
        send(1, 32'h3002D073, 3'b101, 8'h26, 64'h5, 3'b101, 0);
`else
        send(1, 32'h3002D073, 3'b101, 8'h26, 64'h0, 3'b111, 1);
`endif
        drain();

        // Backpressure: four back-to-back inputs while the consumer stalls
        a_out_ready = 1'b0;
        fork
            begin
                for (int t = 1; t <= 4; t++)
                    send(0, (32'(t) << 20) | 32'h93, 3'b000, 8'(t), 64'(t), 3'b000, 0);
            end
            begin
                repeat (2) @(negedge clk);
                check("bp_in_ready_one", 80'(a_in_ready), 80'(1));
                @(negedge clk);
                check("bp_in_ready_two", 80'(a_in_ready), 80'(0));
            end
            begin
                repeat (4) @(posedge clk);
                #1 a_out_ready = 1'b1;
            end
        join
        drain();

        // Reset while both entries are occupied
        a_out_ready = 1'b0;
        send(0, 32'hFFF00093, 3'b000, 8'h31, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 0);
        send(0, 32'h80000037, 3'b000, 8'h32, 64'hFFFF_FFFF_8000_0000, 3'b100, 0);
        check("two_in_ready", 80'(a_in_ready), 80'(0));
        check("two_out_valid", 80'(a_out_valid), 80'(1));
        #2 reset = 1'b1;
        qa.delete();
        #1;
        check("midrst_out_valid", 80'(a_out_valid), 80'(0));
        check("midrst_out_tag", 80'(a_out_tag), 80'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        a_out_ready = 1'b1;
        #1;
        check("postrst_in_ready", 80'(a_in_ready), 80'(1));
        check("postrst_out_valid", 80'(a_out_valid), 80'(0));
        @(posedge clk);
        #1;
        send(0, 32'hFE000EE3, 3'b000, 8'h33, 64'hFFFF_FFFF_FFFF_FFFC, 3'b010, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
